saw_voice_sequencer: RTL and testbench
======================================

Name: saw_voice_sequencer

Overview:
- Time-multiplexes one shared `saw_wave_generator` (combinational, M-bit period in, N-bit saw out) across NCH synth channels.
- Each channel holds a clock-divider counter and an M-bit phase accumulator.
- On each sample tick the block sweeps all channels, one per clock:
  - drives the current channel's phase onto the shared generator;
  - registers the resulting sample;
  - advances that channel's divider and phase.
- Sits between the channel configuration logic (upstream) and the mixer (downstream).

Parameters:
- NCH, 4, number of channels (≥2).
- M, 6, phase width; equals the generator's input width.
- N, 11, sample width; equals the generator's output width (N > M).
- DIVW, 16, divider reload width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  sample-rate strobe, 1-cycle pulse
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  configuration write accepted when high with cfg_valid
- cfg_ch  in  $clog2(NCH)  target channel
- cfg_div  in  DIVW  divider value; phase steps every cfg_div+1 ticks
- cfg_en  in  1  channel enable
- gen_period  out  M  phase presented to the shared generator
- gen_saw  in  N  generator output for gen_period, same cycle
- sample_valid  out  1  sample_out/sample_ch valid, 1-cycle pulse
- sample_ch  out  $clog2(NCH)  channel of sample_out
- sample_out  out  N  registered generator output
- sweep_done  out  1  pulse in the cycle after the last channel is evaluated
- tick_overrun  out  1  pulse when tick arrives while a sweep is in progress

Behaviour:
- Reset (sync, any state, including mid-sweep) clears:
  - state→IDLE, idx=0;
  - all div, en, cnt and phase registers;
  - sample_valid, sample_ch, sample_out, sweep_done and tick_overrun all 0;
  - gen_period=0;
  - cfg_ready=1 from the first cycle after reset.
- FSM states: IDLE, SCAN.
  - IDLE→SCAN on tick, with idx=0.
  - SCAN with idx<NCH-1: idx++.
  - SCAN with idx==NCH-1: →IDLE.
- cfg_ready = (state==IDLE).
- Config write (cfg_valid & cfg_ready), effective next cycle:
  - div[cfg_ch]<=cfg_div, en[cfg_ch]<=cfg_en, cnt[cfg_ch]<=0.
  - If cfg_en=0, phase[cfg_ch]<=0; otherwise phase is retained.
- Config and tick in the same IDLE cycle: both are accepted; the sweep sees the new config.
- cfg_valid during SCAN: not accepted; the requester holds the request.
- gen_period:
  - in SCAN: phase[idx] (pre-update value);
  - in IDLE: 0.
- Each SCAN cycle, for channel idx:
  - sample_out<=gen_saw, sample_ch<=idx, sample_valid<=1, all on the next edge;
  - if en[idx] and cnt[idx]==div[idx]: cnt<=0, phase<=phase+1, modulo 2^M (63→0 wraps silently);
  - else if en[idx]: cnt<=cnt+1;
  - if !en[idx]: cnt and phase hold at 0, and the sample is still emitted (value gen_saw for period 0).
- Timing, with tick at cycle T:
  - channel k is evaluated at T+1+k;
  - sample_valid for channel k is high at T+2+k;
  - sweep_done is high at T+1+NCH, coincident with the last sample_valid;
  - state is IDLE and cfg_ready=1 from T+1+NCH.
- tick seen in SCAN: ignored (no queued sweep) and tick_overrun pulses on the next cycle.
  - tick in the same cycle that state returns to IDLE is accepted normally.
- sample_valid is low in every cycle that does not follow a SCAN cycle.

Test Plan (NCH=4, M=6, N=11; saw(p)={p, 5×p[0]}):
1. Reset, then cfg ch0 div=0 en=1, then 3 ticks spaced 10 cycles -> ch0 samples 0, 63, 64. Channels 1–3 samples 0. sample_ch sequence 0,1,2,3 per sweep. sample_valid at T+2..T+5. sweep_done at T+5.
2. cfg ch1 div=2 en=1, 7 ticks -> ch1 samples 0,0,0,63,63,63,64.
3. ch0 div=0 en=1, 65 ticks -> 64th sample =2047 (phase 63), 65th =0 (wrap).
4. tick, then tick again at T+2 -> tick_overrun pulse at T+3. Only 4 sample_valid pulses. cfg_valid held during the sweep -> cfg_ready=0 T+1..T+4, accepted at T+5.
5. tick and cfg (ch2 div=0 en=1) in the same IDLE cycle -> the sweep emits ch2 sample 0 and the next sweep emits 63. Then cfg ch2 en=0 -> the following sweeps emit 0 for ch2.
6. rst asserted at T+3 mid-sweep -> next cycle: sample_valid=0, cfg_ready=1, all phases 0. After re-cfg of ch0 (div=0, en=1), the first tick yields ch0 sample 0.

Source files
------------

// File: rtl/saw_voice_sequencer_if.sv
// Configuration write port and sample output stream of the saw voice sequencer.
// The sequencer sits on the slave side; config logic/mixer use the master side.
interface saw_voice_sequencer_if #(
  parameter int NCH  = 4,
  parameter int N    = 11,
  parameter int DIVW = 16
);
  localparam int CHW = $clog2(NCH);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch;
  logic [DIVW-1:0] cfg_div;
  logic            cfg_en;

  logic            sample_valid;
  logic [CHW-1:0]  sample_ch;
  logic [N-1:0]    sample_out;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready, sample_valid, sample_ch, sample_out
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready, sample_valid, sample_ch, sample_out
  );
endinterface

// File: rtl/saw_voice_sequencer.sv
// Sweeps NCH channels through one shared combinational saw generator on every
// sample tick, one channel per clock, advancing each channel's divider/phase.
module saw_voice_sequencer #(
  parameter int NCH  = 4,
  parameter int M    = 6,
  parameter int N    = 11,
  parameter int DIVW = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  saw_voice_sequencer_if.slave        bus,
  output logic [M-1:0]                gen_period,
  input  logic [N-1:0]                gen_saw,
  output logic                        sweep_done,
  output logic                        tick_overrun
);
  localparam int CHW = $clog2(NCH);
  localparam logic [CHW-1:0] LAST = CHW'(NCH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_n;
  logic [CHW-1:0]  idx, idx_n;

  logic [DIVW-1:0] div   [NCH];
  logic [DIVW-1:0] cnt   [NCH];
  logic [M-1:0]    phase [NCH];
  logic [NCH-1:0]  en;

  logic            cfg_fire;

  assign bus.cfg_ready = (state == IDLE);
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign gen_period    = (state == SCAN) ? phase[idx] : '0;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: if (tick) begin
        state_n = SCAN;
        idx_n   = '0;
      end
      SCAN: if (idx == LAST) begin
        state_n = IDLE;
        idx_n   = '0;
      end else begin
        idx_n = idx + CHW'(1);
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Config writes only land in IDLE and channel updates only in SCAN, so the
  // two never target the per-channel registers in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        div[i]   <= '0;
        cnt[i]   <= '0;
        phase[i] <= '0;
      end
      en <= '0;
    end else begin
      if (cfg_fire) begin
        div[bus.cfg_ch] <= bus.cfg_div;
        en[bus.cfg_ch]  <= bus.cfg_en;
        cnt[bus.cfg_ch] <= '0;
        if (!bus.cfg_en)
          phase[bus.cfg_ch] <= '0;
      end
      if (state == SCAN && en[idx]) begin
        if (cnt[idx] == div[idx]) begin
          cnt[idx]   <= '0;
          phase[idx] <= phase[idx] + M'(1);
        end else begin
          cnt[idx] <= cnt[idx] + DIVW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sample_valid <= 1'b0;
      bus.sample_ch    <= '0;
      bus.sample_out   <= '0;
      sweep_done       <= 1'b0;
      tick_overrun     <= 1'b0;
    end else begin
      bus.sample_valid <= (state == SCAN);
      sweep_done       <= (state == SCAN) && (idx == LAST);
      tick_overrun     <= (state == SCAN) && tick;
      if (state == SCAN) begin
        bus.sample_ch  <= idx;
        bus.sample_out <= gen_saw;
      end
    end
  end
endmodule

// File: tb/tb_saw_voice_sequencer.sv
// Directed bench for saw_voice_sequencer with a behavioural saw generator
// saw(p) = {p, 5 x p[0]}; per-sweep expected samples are hand-computed.
module tb_saw_voice_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [5:0]  gen_period;
  logic [10:0] gen_saw;
  logic        sweep_done;
  logic        tick_overrun;

  int tests = 0;
  int fails = 0;
  int got [4];

  always #5 clk = ~clk;

  saw_voice_sequencer_if #(.NCH(4), .N(11), .DIVW(16)) bus ();

  assign gen_saw = {gen_period, {5{gen_period[0]}}};

  saw_voice_sequencer #(.NCH(4), .M(6), .N(11), .DIVW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .bus          (bus.slave),
    .gen_period   (gen_period),
    .gen_saw      (gen_saw),
    .sweep_done   (sweep_done),
    .tick_overrun (tick_overrun)
  );

  typedef struct {
    int          mode;   // 0: no cfg, 1: cfg before tick, 2: cfg with tick
    logic [1:0]  ch;
    logic [15:0] div;
    logic        en;
    int          e0, e1, e2, e3;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] div, input logic en);
    chk("cfg_ready_before_cfg", int'(bus.cfg_ready), 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = ch;
    bus.cfg_div   = div;
    bus.cfg_en    = en;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  // Called at a negedge in IDLE; tick is sampled on the next posedge (cycle T).
  task automatic sweep(input bit same, input logic [1:0] ch, input logic [15:0] div,
                       input logic en);
    tick = 1'b1;
    if (same) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = ch;
      bus.cfg_div   = div;
      bus.cfg_en    = en;
    end
    @(negedge clk);
    tick = 1'b0;
    bus.cfg_valid = 1'b0;
    chk("valid_T+1", int'(bus.sample_valid), 0);
    chk("ready_T+1", int'(bus.cfg_ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("valid_in_sweep", int'(bus.sample_valid), 1);
      chk("sample_ch", int'(bus.sample_ch), k);
      chk("sweep_done", int'(sweep_done), (k == 3) ? 1 : 0);
      chk("ready_in_sweep", int'(bus.cfg_ready), (k == 3) ? 1 : 0);
      got[k] = int'(bus.sample_out);
    end
    @(negedge clk);
    chk("valid_after_sweep", int'(bus.sample_valid), 0);
    chk("done_after_sweep", int'(sweep_done), 0);
  endtask

  initial begin
    int nv;
    rst           = 1'b1;
    tick          = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_div   = '0;
    bus.cfg_en    = 1'b0;

    vecs[0]  = '{1, 2'd0, 16'd0, 1'b1,   0,   0,  0, 0};
    vecs[1]  = '{0, 2'd0, 16'd0, 1'b0,  63,   0,  0, 0};
    vecs[2]  = '{0, 2'd0, 16'd0, 1'b0,  64,   0,  0, 0};
    vecs[3]  = '{1, 2'd1, 16'd2, 1'b1, 127,   0,  0, 0};
    vecs[4]  = '{0, 2'd0, 16'd0, 1'b0, 128,   0,  0, 0};
    vecs[5]  = '{0, 2'd0, 16'd0, 1'b0, 191,   0,  0, 0};
    vecs[6]  = '{0, 2'd0, 16'd0, 1'b0, 192,  63,  0, 0};
    vecs[7]  = '{0, 2'd0, 16'd0, 1'b0, 255,  63,  0, 0};
    vecs[8]  = '{0, 2'd0, 16'd0, 1'b0, 256,  63,  0, 0};
    vecs[9]  = '{0, 2'd0, 16'd0, 1'b0, 319,  64,  0, 0};
    vecs[10] = '{2, 2'd2, 16'd0, 1'b1, 320,  64,  0, 0};
    vecs[11] = '{0, 2'd0, 16'd0, 1'b0, 383,  64, 63, 0};
    vecs[12] = '{1, 2'd2, 16'd0, 1'b0, 384, 127,  0, 0};
    vecs[13] = '{0, 2'd0, 16'd0, 1'b0, 447, 127,  0, 0};

    @(negedge clk);
    do_reset();
    chk("rst_sample_valid", int'(bus.sample_valid), 0);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_gen_period", int'(gen_period), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_tick_overrun", int'(tick_overrun), 0);
    chk("rst_sample_out", int'(bus.sample_out), 0);

    // Basic stepping, divider, same-cycle cfg+tick, disable.
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].mode == 1) cfg(vecs[v].ch, vecs[v].div, vecs[v].en);
      sweep(vecs[v].mode == 2, vecs[v].ch, vecs[v].div, vecs[v].en);
      chk($sformatf("vec%0d_ch0", v), got[0], vecs[v].e0);
      chk($sformatf("vec%0d_ch1", v), got[1], vecs[v].e1);
      chk($sformatf("vec%0d_ch2", v), got[2], vecs[v].e2);
      chk($sformatf("vec%0d_ch3", v), got[3], vecs[v].e3);
      repeat (4) @(negedge clk);
    end

    // Overrun tick at T+2, cfg held through the sweep.
    nv = 0;
    tick = 1'b1;
    @(negedge clk);                           // T+1
    tick = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd3; bus.cfg_div = 16'd0; bus.cfg_en = 1'b1;
    chk("ovr_ready_T+1", int'(bus.cfg_ready), 0);
    nv += int'(bus.sample_valid);
    @(negedge clk);                           // T+2
    tick = 1'b1;
    chk("ovr_ready_T+2", int'(bus.cfg_ready), 0);
    chk("ovr_flag_T+2", int'(tick_overrun), 0);
    nv += int'(bus.sample_valid);
    @(negedge clk);                           // T+3
    tick = 1'b0;
    chk("ovr_flag_T+3", int'(tick_overrun), 1);
    chk("ovr_ready_T+3", int'(bus.cfg_ready), 0);
    nv += int'(bus.sample_valid);
    @(negedge clk);                           // T+4
    chk("ovr_flag_T+4", int'(tick_overrun), 0);
    chk("ovr_ready_T+4", int'(bus.cfg_ready), 0);
    nv += int'(bus.sample_valid);
    @(negedge clk);                           // T+5
    chk("ovr_ready_T+5", int'(bus.cfg_ready), 1);
    nv += int'(bus.sample_valid);
    @(negedge clk);                           // T+6
    bus.cfg_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      nv += int'(bus.sample_valid);
      @(negedge clk);
    end
    chk("ovr_valid_count", nv, 4);
    sweep(1'b0, 2'd0, 16'd0, 1'b0);
    chk("ovr_ch3_first", got[3], 0);
    sweep(1'b0, 2'd0, 16'd0, 1'b0);
    chk("ovr_ch3_second", got[3], 63);

    // Reset in the middle of a sweep.
    tick = 1'b1;
    @(negedge clk);                           // T+1
    tick = 1'b0;
    @(negedge clk);                           // T+2
    @(negedge clk);                           // T+3
    rst = 1'b1;
    @(negedge clk);                           // T+4
    rst = 1'b0;
    chk("midrst_valid", int'(bus.sample_valid), 0);
    chk("midrst_ready", int'(bus.cfg_ready), 1);
    chk("midrst_gen_period", int'(gen_period), 0);
    chk("midrst_done", int'(sweep_done), 0);
    @(negedge clk);
    chk("midrst_valid_next", int'(bus.sample_valid), 0);
    cfg(2'd0, 16'd0, 1'b1);
    sweep(1'b0, 2'd0, 16'd0, 1'b0);
    chk("midrst_ch0", got[0], 0);
    chk("midrst_ch1", got[1], 0);
    chk("midrst_ch3", got[3], 0);
    sweep(1'b0, 2'd0, 16'd0, 1'b0);
    chk("midrst_ch0_next", got[0], 63);
    chk("midrst_ch3_next", got[3], 0);

    // Phase wrap 63 -> 0.
    do_reset();
    cfg(2'd0, 16'd0, 1'b1);
    for (int s = 1; s <= 65; s++) begin
      sweep(1'b0, 2'd0, 16'd0, 1'b0);
      if (s == 64) chk("wrap_phase63", got[0], 2047);
      if (s == 65) chk("wrap_phase0", got[0], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
